// File: rtl/matrix_frame_buffer.sv
// matrix_frame_buffer
// 8x8 (parameterisable) frame store that feeds the matrix LED row scanner.
// A producer writes row words over a valid/ready port; the scanner's one-hot
// row select picks the displayed row word combinationally.
//
// Build option: define MATRIX_FB_DOUBLE_BUFFER_EN for double buffering.
//   Defined  : writes go to a back buffer; a wr_last commit swaps front and
//              back on the scanner's next frame_start, so the display never
//              shows a half-written frame.
//   Undefined: a single buffer is written in place and is visible on the
//              next cycle; wr_ready is always 1 and frame_start is unused.
module matrix_frame_buffer #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [COLS-1:0]          wr_data,
  input  logic                     wr_last,
  input  logic [ROWS-1:0]          scan_row,
  input  logic                     frame_start,
  output logic [COLS-1:0]          scan_data,
  output logic                     swap_pending,
  output logic [7:0]               frame_count
);

  // Row words currently on display, one per row.
  logic [COLS-1:0] front [ROWS];

  // A row select with zero or several bits set must blank the columns.
  logic sel_onehot;
  assign sel_onehot = (scan_row != '0) && ((scan_row & (scan_row - ROWS'(1))) == '0);

  logic wr_fire;
  assign wr_fire = wr_valid && wr_ready;

`ifdef MATRIX_FB_DOUBLE_BUFFER_EN

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } fb_state_t;

  fb_state_t       state;
  logic            front_sel;
  logic [COLS-1:0] buf_a [ROWS];
  logic [COLS-1:0] buf_b [ROWS];

  // Commit/swap FSM; wr_ready and swap_pending are registered with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FILL;
      wr_ready     <= 1'b1;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      frame_count  <= 8'd0;
    end else begin
      case (state)
        FILL: begin
          // A frame_start here is ignored, including one that coincides
          // with the wr_last acceptance: the swap needs a later pulse.
          if (wr_fire && wr_last) begin
            state        <= WAIT_SWAP;
            wr_ready     <= 1'b0;
            swap_pending <= 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (frame_start) begin
            state        <= FILL;
            wr_ready     <= 1'b1;
            swap_pending <= 1'b0;
            front_sel    <= ~front_sel;
            frame_count  <= frame_count + 8'd1;
          end
        end
        default: begin
          state        <= FILL;
          wr_ready     <= 1'b1;
          swap_pending <= 1'b0;
        end
      endcase
    end
  end

  // Accepted words land in the back buffer (the one not selected by front_sel).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROWS; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else if (wr_fire) begin
      if (front_sel) buf_a[wr_row] <= wr_data;
      else           buf_b[wr_row] <= wr_data;
    end
  end

  // Front buffer view; no copy is made on a swap, only the selector flips.
  always_comb begin
    for (int k = 0; k < ROWS; k++) begin
      front[k] = front_sel ? buf_b[k] : buf_a[k];
    end
  end

`else

  logic [COLS-1:0] buf_a [ROWS];
  logic            unused_frame_start;

  assign unused_frame_start = frame_start;
  assign wr_ready           = 1'b1;
  assign swap_pending       = 1'b0;

  // Frames are counted at the producer's wr_last, since there is no swap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 8'd0;
    end else if (wr_fire && wr_last) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  // Single buffer written in place; visible on scan_data from the next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROWS; i++) begin
        buf_a[i] <= '0;
      end
    end else if (wr_fire) begin
      buf_a[wr_row] <= wr_data;
    end
  end

  // The only buffer is the displayed one.
  always_comb begin
    for (int k = 0; k < ROWS; k++) begin
      front[k] = buf_a[k];
    end
  end

`endif

  // Row select decode: OR of the front words gated by a valid one-hot select.
  always_comb begin
    scan_data = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (sel_onehot && scan_row[k]) scan_data = scan_data | front[k];
    end
  end

endmodule

// File: doc/matrix_frame_buffer.md
# matrix_frame_buffer

Double-buffered 8x8 frame store that sits directly upstream of the matrix LED row scanner. A producer writes complete frames row by row over a valid/ready port into a back buffer. On a frame commit, the block swaps buffers at the scanner's next frame boundary, so the display never shows a half-written frame. The scanner's one-hot row select indexes the front buffer combinationally to produce the column data `d`.

## Interface

Parameters:
- `ROWS`, default 8: number of matrix rows; must be a power of two ≥ 2.
- `COLS`, default 8: columns per row; width of a row word.

Ports:
- `clock`, in, 1: single system clock (27 MHz on Tang Nano 9K).
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `wr_valid`, in, 1: producer has a row word.
- `wr_ready`, out, 1: block accepts a row word this cycle.
- `wr_row`, in, `$clog2(ROWS)`: binary row index of the word.
- `wr_data`, in, `COLS`: row pattern; bit i drives column i.
- `wr_last`, in, 1: the accepted word completes a frame and requests a commit.
- `scan_row`, in, `ROWS`: one-hot row select from the scanner.
- `frame_start`, in, 1: one-cycle pulse from the scanner on the cycle its row select wraps to row 0.
- `scan_data`, out, `COLS`: front-buffer word for `scan_row`.
- `swap_pending`, out, 1: a commit is waiting for `frame_start`.
- `frame_count`, out, 8: count of completed swaps; wraps modulo 256.

## Operation

- Storage: two `ROWS`×`COLS` register arrays, `buf[0]` and `buf[1]`, plus a `front_sel` bit. The back buffer is `buf[~front_sel]`.
- A write is accepted on a rising edge with `wr_valid && wr_ready`. It stores `wr_data` into `back[wr_row]`.
- `scan_data` is combinational: `front[k]` when `scan_row` is one-hot with bit k set; otherwise all zeros (covers no bits set and more than one bit set).
- FSM with two states:
  - `FILL`: `wr_ready=1`. An accepted write with `wr_last=1` moves the FSM to `WAIT_SWAP`.
  - `WAIT_SWAP`: `wr_ready=0`, `swap_pending=1`. On an edge with `frame_start=1`, toggle `front_sel`, increment `frame_count`, and return to `FILL`.
- No copy is made on swap. The new back buffer holds the frame that was displayed before the swap. Producers rewrite every row they care about.
- Simultaneous events:
  - If `wr_last` is accepted in the same cycle as `frame_start`, the swap waits for the next `frame_start`. The swap only occurs in `WAIT_SWAP`.
  - A `frame_start` pulse in `FILL` is ignored.
- Reset mid-operation: all state returns to reset values immediately. Any pending commit and any partially written frame are discarded.
- Reset values: both buffers all zero, `front_sel=0`, FSM=`FILL`, `wr_ready=1`, `swap_pending=0`, `frame_count=0`, `scan_data=0` for any `scan_row`.

## Timing

- Write latency: an accepted word lands in the back buffer on the acceptance edge. With double buffering, it is not visible on `scan_data` until after the swap.
- Commit: `swap_pending` and `wr_ready=0` take effect the cycle after the `wr_last` acceptance.
- Swap: `front_sel` toggles on the `frame_start` edge. `scan_data` shows the new frame from the next cycle, combinationally from `scan_row`. On that same edge, `swap_pending` returns to 0, `wr_ready` returns to 1, and `frame_count` increments.
- Worst-case backpressure: one full scan frame (`ROWS` × refresh interval).

## Configuration

- `MATRIX_FB_DOUBLE_BUFFER_EN` defined: behaviour exactly as described above.
- `MATRIX_FB_DOUBLE_BUFFER_EN` undefined:
  - Only `buf[0]` exists; no `front_sel`, no FSM.
  - Writes land directly in the displayed buffer; `scan_data` reflects an accepted write from the next cycle.
  - `wr_ready` is tied to 1 and `swap_pending` to 0. `frame_start` is ignored.
  - `frame_count` increments on each accepted write with `wr_last=1`.

## Test plan

- **Reset:** assert `reset_n=0` mid-write, then release → `scan_data=0` for all 8 one-hot rows, `wr_ready=1`, `swap_pending=0`, `frame_count=0`.
- **Fill and swap (double buffer):** write X pattern `81,42,24,18,18,24,42,81` (hex), rows 0–7, with `wr_last` on row 7 → `scan_data` stays 0 and `swap_pending=1` until `frame_start`. The cycle after, `scan_row=8'b0000_1000` gives `18` and `frame_count=1`.
- **Backpressure:** hold `wr_valid=1` during `WAIT_SWAP` → no writes accepted and the back buffer is unchanged. The first accept occurs on the edge after the swap.
- **Simultaneous:** `wr_last` accepted in the same cycle as `frame_start` → no swap on that edge. The swap occurs on the next `frame_start` pulse.
- **Invalid select:** `scan_row=8'b0000_0000`, then `8'b0000_0011` → `scan_data=0` both times.
- **Macro off:** write `wr_row=2`, `wr_data=FF` → the next cycle, `scan_row=8'b0000_0100` gives `FF`. `wr_ready` is constantly 1, and `wr_last` increments `frame_count` immediately.
